// File: rtl/ticket_pkg.sv
// ----------------------------------------------------------------------------
// ticket_pkg
// Shared types and constants for the multi-ticket vending controller.
//   vend_state_t   : controller state encoding
//   DEFAULT_PRICES : packed default price table (type 0 in the LSBs)
//   paid_width()   : width needed for due/paid/change values
// ----------------------------------------------------------------------------
package ticket_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PAY      = 3'd1,
      DISPENSE = 3'd2,
      CHANGE   = 3'd3,
      REFUND   = 3'd4
   } vend_state_t;

   // Prices for types 3..0: 30, 20, 10, 5
   localparam logic [31:0] DEFAULT_PRICES = {8'd30, 8'd20, 8'd10, 8'd5};

   // One extra bit beyond price*count leaves headroom for overpayment
   function automatic int paid_width(input int money_w, input int cnt_w);
      return money_w + cnt_w + 1;
   endfunction

endpackage

// File: rtl/ticket_timeout_timer.sv
// ----------------------------------------------------------------------------
// ticket_timeout_timer
// Reloadable inactivity down-counter. A restart loads TIMEOUT-1; while run is
// high the count walks down to zero, and expire is high during the cycle in
// which the count sits at zero, so the owner acts on the edge exactly TIMEOUT
// cycles after the last restart.
// Ports:
//   clk     in  : clock, rising edge
//   rst     in  : synchronous active-low reset
//   restart in  : reload the counter (entry to the waiting state or activity)
//   run     in  : counting enable (owner is in its waiting state)
//   expire  out : timeout reached this cycle
// ----------------------------------------------------------------------------
module ticket_timeout_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic run,
   output logic expire
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT - 1);

   logic [CW-1:0] count;

   // Reload on restart, otherwise count down and park at zero
   always_ff @(posedge clk) begin
      if (!rst) begin
         count <= '0;
      end else if (restart) begin
         count <= RELOAD;
      end else if (run && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign expire = run && (count == '0);

endmodule

// File: rtl/ticket_vend_ctrl.sv
// ----------------------------------------------------------------------------
// ticket_vend_ctrl
// Multi-ticket vending controller. Latches a ticket type and count, collects
// coins through a ready/valid handshake, then either dispenses one pulse per
// ticket followed by a change strobe, or refunds everything on cancel or on
// inactivity timeout.
// Ports:
//   clk, rst                 : clock and synchronous active-low reset
//   sel_valid/type/count     : ticket selection from the keypad
//   sel_err                  : one-cycle pulse after a rejected selection
//   coin_valid/value/ready   : coin handshake (ready is combinational)
//   sure, nsure              : confirm / cancel
//   ticket_pulse             : one cycle high per ticket dispensed
//   change_valid/amount      : change or refund transfer strobe
//   refund                   : transfer is a refund, not change
//   paid, due                : running coin total and latched price*count
//   busy                     : controller is not idle
// ----------------------------------------------------------------------------
module ticket_vend_ctrl
   import ticket_pkg::*;
#(
   parameter int NUM_TYPES = 4,
   parameter int TYPE_W    = 2,
   parameter int CNT_W     = 3,
   parameter int MONEY_W   = 8,
   parameter logic [NUM_TYPES*MONEY_W-1:0] PRICES = DEFAULT_PRICES,
   parameter int TIMEOUT   = 255,
   parameter int PAID_W    = paid_width(MONEY_W, CNT_W)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sel_valid,
   input  logic [TYPE_W-1:0]  sel_type,
   input  logic [CNT_W-1:0]   sel_count,
   output logic               sel_err,
   input  logic               coin_valid,
   input  logic [MONEY_W-1:0] coin_value,
   output logic               coin_ready,
   input  logic               sure,
   input  logic               nsure,
   output logic               ticket_pulse,
   output logic               change_valid,
   output logic [PAID_W-1:0]  change_amount,
   output logic               refund,
   output logic [PAID_W-1:0]  paid,
   output logic [PAID_W-1:0]  due,
   output logic               busy
);

   vend_state_t state, next_state;

   logic [CNT_W-1:0]  left;
   logic [PAID_W:0]   coin_sum;
   logic              coin_take;
   logic              sel_ok;
   logic              sel_bad;
   logic              timer_restart;
   logic              timer_expire;

   // Price lookup that stays safe for type codes beyond the table
   function automatic logic [MONEY_W-1:0] price_of(input logic [TYPE_W-1:0] t);
      logic [MONEY_W-1:0] p;
      p = '0;
      for (int i = 0; i < NUM_TYPES; i++) begin
         if (int'(t) == i) begin
            p = PRICES[i*MONEY_W +: MONEY_W];
         end
      end
      return p;
   endfunction

   // One extra bit catches a coin that would wrap the paid total
   assign coin_sum   = {1'b0, paid} + {{(PAID_W + 1 - MONEY_W){1'b0}}, coin_value};
   assign coin_ready = (state == PAY) && !coin_sum[PAID_W];

   ticket_timeout_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .restart (timer_restart),
      .run     (state == PAY),
      .expire  (timer_expire)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; cancel and timeout both outrank a confirm
   always_comb begin
      next_state    = state;
      coin_take     = 1'b0;
      sel_ok        = 1'b0;
      sel_bad       = 1'b0;
      timer_restart = 1'b0;
      case (state)
         IDLE: begin
            if (sel_valid) begin
               if ((sel_count != '0) && (int'(sel_type) < NUM_TYPES)) begin
                  sel_ok     = 1'b1;
                  next_state = PAY;
               end else begin
                  sel_bad = 1'b1;
               end
            end
         end
         PAY: begin
            coin_take = coin_valid && coin_ready;
            if (nsure || timer_expire) begin
               next_state = REFUND;
            end else if (sure && (paid >= due)) begin
               next_state = DISPENSE;
            end
         end
         DISPENSE: begin
            if (left <= CNT_W'(1)) begin
               next_state = CHANGE;
            end
         end
         CHANGE:  next_state = IDLE;
         REFUND:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
      timer_restart = sel_ok || coin_take;
   end

   // Transaction datapath: selection latch, coin total, tickets remaining
   always_ff @(posedge clk) begin
      if (!rst) begin
         paid    <= '0;
         due     <= '0;
         left    <= '0;
         sel_err <= 1'b0;
      end else begin
         sel_err <= sel_bad;
         case (state)
            IDLE: begin
               if (sel_ok) begin
                  due  <= PAID_W'(price_of(sel_type)) * PAID_W'(sel_count);
                  paid <= '0;
                  left <= sel_count;
               end
            end
            PAY: begin
               if (coin_take) begin
                  paid <= coin_sum[PAID_W-1:0];
               end
            end
            DISPENSE: begin
               left <= left - CNT_W'(1);
            end
            CHANGE, REFUND: begin
               paid <= '0;
               due  <= '0;
               left <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs decode directly from the registered state, so reset clears them
   assign busy          = (state != IDLE);
   assign ticket_pulse  = (state == DISPENSE);
   assign change_valid  = (state == CHANGE) || (state == REFUND);
   assign refund        = (state == REFUND);
   assign change_amount = (state == CHANGE) ? (paid - due) :
                          (state == REFUND) ? paid : '0;

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ticket_vend_ctrl
// Self-checking bench for ticket_vend_ctrl. Dispense/transfer events are
// predicted when confirm/cancel/timeout stimulus is issued and matched, with
// their cycle, by a monitor on the falling edge.
// ----------------------------------------------------------------------------
module tb_ticket_vend_ctrl;

   localparam int PAID_W  = 12;
   localparam int MAXPAID = 4095;
   localparam int TMO     = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              sel_valid;
   logic [1:0]        sel_type;
   logic [2:0]        sel_count;
   logic              sel_err;
   logic              coin_valid;
   logic [7:0]        coin_value;
   logic              coin_ready;
   logic              sure;
   logic              nsure;
   logic              ticket_pulse;
   logic              change_valid;
   logic [PAID_W-1:0] change_amount;
   logic              refund;
   logic [PAID_W-1:0] paid;
   logic [PAID_W-1:0] due;
   logic              busy;

   ticket_vend_ctrl #(
      .TIMEOUT (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .sel_valid     (sel_valid),
      .sel_type      (sel_type),
      .sel_count     (sel_count),
      .sel_err       (sel_err),
      .coin_valid    (coin_valid),
      .coin_value    (coin_value),
      .coin_ready    (coin_ready),
      .sure          (sure),
      .nsure         (nsure),
      .ticket_pulse  (ticket_pulse),
      .change_valid  (change_valid),
      .change_amount (change_amount),
      .refund        (refund),
      .paid          (paid),
      .due           (due),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit isChange;
      int amount;
      bit isRefund;
      int cycle;
   } vendEvent_t;

   vendEvent_t expQ[$];
   vendEvent_t monEvent;

   int prices[4] = '{5, 10, 20, 30};
   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int expPaid  = 0;
   int expDue   = 0;
   int expCount = 0;
   int eCycle   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit sv, input int st, input int sc, input bit cv,
                                input int cval, input bit s, input bit ns);
      sel_valid  = sv;
      sel_type   = 2'(st);
      sel_count  = 3'(sc);
      coin_valid = cv;
      coin_value = 8'(cval);
      sure       = s;
      nsure      = ns;
      #1;
   endtask

   task automatic clockCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic pushEvent(input bit isChange, input int amount, input bit isRefund, input int cycle);
      vendEvent_t ev;
      ev.isChange = isChange;
      ev.amount   = amount;
      ev.isRefund = isRefund;
      ev.cycle    = cycle;
      expQ.push_back(ev);
   endtask

   // Every ticket pulse or transfer strobe must match the next predicted event
   always @(negedge clk) begin
      if (ticket_pulse || change_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected output event", 32'd1, 32'd0);
         end else begin
            monEvent = expQ.pop_front();
            checkOutput("event kind", 32'(change_valid), 32'(monEvent.isChange));
            checkOutput("event cycle", 32'(cyc), 32'(monEvent.cycle));
            if (monEvent.isChange) begin
               checkOutput("change_amount", 32'(change_amount), 32'(monEvent.amount));
               checkOutput("refund flag", 32'(refund), 32'(monEvent.isRefund));
            end
         end
      end
   end

   task automatic selectTicket(input int t, input int c);
      applyStimulus(1'b1, t, c, 1'b0, 0, 1'b0, 1'b0);
      clockCycle();
      idleInputs();
      expDue   = prices[t] * c;
      expPaid  = 0;
      expCount = c;
      checkOutput("busy after select", 32'(busy), 32'd1);
      checkOutput("due after select", 32'(due), 32'(expDue));
      checkOutput("paid after select", 32'(paid), 32'd0);
   endtask

   task automatic insertCoin(input int v);
      bit rdy;
      rdy = (expPaid + v) <= MAXPAID;
      applyStimulus(1'b0, 0, 0, 1'b1, v, 1'b0, 1'b0);
      checkOutput("coin_ready", 32'(coin_ready), 32'(rdy));
      clockCycle();
      idleInputs();
      if (rdy) expPaid += v;
      checkOutput("paid after coin", 32'(paid), 32'(expPaid));
   endtask

   // Confirm/cancel, predict the resulting events, then check return to IDLE
   task automatic finishPurchase(input bit s, input bit ns);
      int waitCycles;
      applyStimulus(1'b0, 0, 0, 1'b0, 0, s, ns);
      clockCycle();
      eCycle = cyc;
      idleInputs();
      if (ns) begin
         pushEvent(1'b1, expPaid, 1'b1, eCycle);
         waitCycles = 1;
      end else begin
         for (int i = 0; i < expCount; i++) pushEvent(1'b0, 0, 1'b0, eCycle + i);
         pushEvent(1'b1, expPaid - expDue, 1'b0, eCycle + expCount);
         waitCycles = expCount + 1;
      end
      repeat (waitCycles) clockCycle();
      checkOutput("busy back in idle", 32'(busy), 32'd0);
      checkOutput("paid cleared", 32'(paid), 32'd0);
      checkOutput("due cleared", 32'(due), 32'd0);
      expPaid = 0;
      expDue  = 0;
   endtask

   initial begin
      idleInputs();
      rst = 1'b0;
      repeat (2) clockCycle();
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset paid", 32'(paid), 32'd0);
      checkOutput("reset due", 32'(due), 32'd0);
      checkOutput("reset ticket_pulse", 32'(ticket_pulse), 32'd0);
      checkOutput("reset change_valid", 32'(change_valid), 32'd0);
      checkOutput("reset sel_err", 32'(sel_err), 32'd0);
      checkOutput("reset coin_ready", 32'(coin_ready), 32'd0);
      rst = 1'b1;
      clockCycle();

      $display("[TB] exact payment");
      selectTicket(1, 2);
      insertCoin(10);
      insertCoin(10);
      finishPurchase(1'b1, 1'b0);

      $display("[TB] overpay, max count");
      selectTicket(3, 7);
      insertCoin(200);
      insertCoin(50);
      finishPurchase(1'b1, 1'b0);

      $display("[TB] cancel with sure and nsure together");
      selectTicket(0, 1);
      insertCoin(3);
      finishPurchase(1'b1, 1'b1);

      $display("[TB] inactivity timeout");
      selectTicket(2, 1);
      insertCoin(5);
      pushEvent(1'b1, 5, 1'b1, cyc + TMO);
      repeat (TMO - 1) clockCycle();
      checkOutput("busy before timeout", 32'(busy), 32'd1);
      checkOutput("no strobe before timeout", 32'(change_valid), 32'd0);
      clockCycle();
      checkOutput("timeout strobe", 32'(change_valid), 32'd1);
      checkOutput("timeout refund flag", 32'(refund), 32'd1);
      clockCycle();
      checkOutput("idle after timeout", 32'(busy), 32'd0);
      expPaid = 0;

      $display("[TB] rejected selection");
      applyStimulus(1'b1, 2, 0, 1'b0, 0, 1'b0, 1'b0);
      clockCycle();
      idleInputs();
      checkOutput("sel_err on count 0", 32'(sel_err), 32'd1);
      checkOutput("still idle after reject", 32'(busy), 32'd0);
      clockCycle();
      checkOutput("sel_err is one pulse", 32'(sel_err), 32'd0);

      $display("[TB] underpaid confirm ignored");
      selectTicket(1, 1);
      insertCoin(5);
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0);
      clockCycle();
      idleInputs();
      checkOutput("still paying after short sure", 32'(busy), 32'd1);
      checkOutput("paid kept after short sure", 32'(paid), 32'd5);
      insertCoin(5);
      finishPurchase(1'b1, 1'b0);

      $display("[TB] paid overflow guard");
      selectTicket(3, 7);
      repeat (16) insertCoin(255);
      insertCoin(255);
      insertCoin(15);
      finishPurchase(1'b1, 1'b0);

      $display("[TB] reset during dispense");
      selectTicket(1, 3);
      insertCoin(60);
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b1, 1'b0);
      clockCycle();
      eCycle = cyc;
      idleInputs();
      pushEvent(1'b0, 0, 1'b0, eCycle);
      pushEvent(1'b0, 0, 1'b0, eCycle + 1);
      clockCycle();
      checkOutput("second ticket pulse", 32'(ticket_pulse), 32'd1);
      rst = 1'b0;
      clockCycle();
      checkOutput("mid-reset busy", 32'(busy), 32'd0);
      checkOutput("mid-reset ticket_pulse", 32'(ticket_pulse), 32'd0);
      checkOutput("mid-reset change_valid", 32'(change_valid), 32'd0);
      checkOutput("mid-reset change_amount", 32'(change_amount), 32'd0);
      checkOutput("mid-reset paid", 32'(paid), 32'd0);
      checkOutput("mid-reset due", 32'(due), 32'd0);
      rst = 1'b1;
      repeat (4) clockCycle();
      checkOutput("idle after mid reset", 32'(busy), 32'd0);
      expPaid = 0;

      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ticket_vend_ctrl.md
# ticket_vend_ctrl

Parametrised multi-ticket vending controller: the next-generation ticket/payment control stage of the AutoSellTicket design. It latches a selection of ticket type and count and accumulates coins over many cycles through a ready/valid handshake. On confirmation it issues one ticket pulse per ticket and then a single change transfer. Cancellation or an inactivity timeout triggers a full refund. The block sits between the keypad/coin front-end and the dispenser/change-return actuators.

## Interface
- `NUM_TYPES`, 4 — number of ticket types.
- `TYPE_W`, 2 — width of the ticket-type field; must satisfy `2**TYPE_W >= NUM_TYPES`.
- `CNT_W`, 3 — width of the ticket-count field; the maximum count is `2**CNT_W-1`.
- `MONEY_W`, 8 — width of the coin value and of each price.
- `PRICES`, `{8'd30,8'd20,8'd10,8'd5}` — packed price table, `NUM_TYPES*MONEY_W` bits; type 0 occupies the LSBs.
- `TIMEOUT`, 255 — number of idle cycles in PAY before an automatic refund; must be ≥1.
- `PAID_W`, `MONEY_W+CNT_W+1` — derived; width of the amount due, the amount paid and the change.

Ports:
- `clk` in 1 — single clock; all logic is on the rising edge.
- `rst` in 1 — synchronous, active-low reset.
- `sel_valid` in 1 — a selection is presented this cycle.
- `sel_type` in `TYPE_W` — ticket type.
- `sel_count` in `CNT_W` — number of tickets.
- `sel_err` out 1 — one-cycle pulse when a selection is rejected.
- `coin_valid` in 1 — a coin is offered.
- `coin_value` in `MONEY_W` — value of the offered coin.
- `coin_ready` out 1 — combinational; the coin is accepted when `coin_valid && coin_ready`.
- `sure` in 1 — confirm purchase.
- `nsure` in 1 — cancel purchase.
- `ticket_pulse` out 1 — one pulse per ticket dispensed.
- `change_valid` out 1 — one-cycle strobe qualifying `change_amount`.
- `change_amount` out `PAID_W` — change or refund value.
- `refund` out 1 — high with `change_valid` when the transfer is a refund rather than change.
- `paid` out `PAID_W` — running total of accepted coins.
- `due` out `PAID_W` — latched price multiplied by count.
- `busy` out 1 — high in every state except IDLE.

## Operation
- State machine: IDLE, PAY, DISPENSE, CHANGE, REFUND.
- **Reset** (`rst` low at the clock edge) → IDLE. Every output register is cleared to 0: `ticket_pulse`, `change_valid`, `change_amount`, `refund`, `paid`, `due`, `sel_err`, `busy`. The dispense and timeout counters are also cleared. Reset applied in any state aborts the transaction without a refund strobe.
- **IDLE**:
  - A selection with `sel_valid`, `sel_count≠0` and `sel_type<NUM_TYPES` is accepted: `due ← PRICES[sel_type]*sel_count`, computed at full `PAID_W` width with no truncation; `paid ← 0`; next state PAY.
  - A selection with `sel_count=0` or an out-of-range type is rejected: `sel_err` pulses and the state stays IDLE.
  - `coin_ready` is 0.
- **PAY**:
  - `coin_ready = (paid + coin_value <= 2**PAID_W-1)`. A handshaken coin is added to `paid` and restarts the timeout counter.
  - `nsure` → REFUND. `nsure` has priority over `sure`.
  - `sure` with the registered `paid >= due` → DISPENSE. A coin arriving in the same cycle is still accepted and ends up in the change.
  - `sure` with `paid < due` is ignored.
  - The timeout counter reaching `TIMEOUT` → REFUND.
  - A coin handshaken in the same cycle as `nsure` or the timeout is included in the refund.
  - `sel_valid` is ignored.
- **DISPENSE**: `ticket_pulse` is high for exactly `count` consecutive cycles, then the state moves to CHANGE. `coin_ready` is 0, and `sure`/`nsure` are ignored.
- **CHANGE**: for one cycle, `change_valid=1`, `change_amount=paid-due` and `refund=0`. This strobe is issued even when the change is 0. Next state IDLE, with `paid` and `due` cleared.
- **REFUND**: for one cycle, `change_valid=1`, `change_amount=paid` and `refund=1`. This strobe is issued even when `paid=0`. Next state IDLE, with `paid` and `due` cleared.

## Timing
- Selection accepted at edge t → `busy` is 1 and `due` is valid from t+1.
- A coin handshaken at edge t is reflected in `paid` at t+1.
- `sure` accepted at edge t → `ticket_pulse` high during cycles t+1 … t+count, `change_valid` high at t+count+1, IDLE at t+count+2.
- `nsure` or timeout at edge t → `change_valid` with `refund` high at t+1, IDLE at t+2.
- The earliest a new selection can be accepted is the first cycle back in IDLE.
- Timeout: REFUND is entered `TIMEOUT` cycles after entry to PAY or after the last accepted coin, whichever is later.

## Structure
- Package `ticket_pkg` holds:
  - the state enum `vend_state_t`;
  - the default `PRICES` localparam;
  - a `PAID_W` helper function.
- Sub-module `ticket_timeout_timer`: a loadable down-counter with restart and expiry pulse, parametrised by `TIMEOUT`.

## Test plan
- **Exact payment.** Defaults. Select type 1, count 2 (`due=20`); coins 10,10; `sure` → 2 `ticket_pulse` cycles, then change strobe with `change_amount=0`, `refund=0`.
- **Overpay, max count.** Select type 3, count 7 (`due=210`); coins 200, 50; `sure` → 7 ticket pulses, then change 40.
- **Cancel with coins.** Select type 0, count 1; coin 3; `nsure` and `sure` asserted together → no ticket pulses; refund strobe with 3 and `refund=1`.
- **Timeout.** `TIMEOUT=8`. Select, then coin 5, then no activity → REFUND exactly 8 cycles after the coin, `change_amount=5`.
- **Rejects.** `sel_count=0` → `sel_err` pulse and the state stays IDLE. In PAY, `sure` with `paid=5 < due=10` is ignored. A coin that would overflow `paid` sees `coin_ready=0`.
- **Reset mid-dispense.** `rst` low during the 2nd ticket pulse → all outputs 0 next cycle and IDLE; no change strobe.
